// File: rtl/no_overflow_sub_pipe.sv
// rtl/no_overflow_sub_pipe.sv - two-stage saturating A-B subtractor, signed/unsigned per op
// Optional sticky overflow flags: define NO_OVERFLOW_SUB_STICKY_EN.
module no_overflow_sub_pipe #(
   parameter int WIDTH       = 32,
   parameter int UNSIG_CLAMP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_po,
   output logic             out_no
`ifdef NO_OVERFLOW_SUB_STICKY_EN
   ,
   input  logic             sticky_clr,
   output logic             sticky_po,
   output logic             sticky_no
`endif
);

   localparam int              UB    = WIDTH - 1;
   localparam logic [WIDTH-1:0] P_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] N_MAX = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ZERO  = '0;

   // stage 1 holds the operands plus the raw modular difference
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_signed;
   logic [WIDTH-1:0] s1_diff;

   // stage 2 is the output register itself
   logic             s2_valid;
   logic             s2_adv;
   logic             s1_adv;

   logic [WIDTH-1:0] sat_result;
   logic             sat_po;
   logic             sat_no;

   // an empty downstream stage always advances, so bubbles collapse
   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   // stage 1: capture operands and raw difference on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_a      <= ZERO;
         s1_b      <= ZERO;
         s1_signed <= 1'b0;
         s1_diff   <= ZERO;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a      <= in_a;
            s1_b      <= in_b;
            s1_signed <= in_signed;
            s1_diff   <= in_a - in_b;
         end
      end
   end

   // overflow detection and clamping from the stage-1 difference
   always_comb begin
      sat_po     = 1'b0;
      sat_no     = 1'b0;
      sat_result = s1_diff;
      if (s1_signed) begin
         // sign of the difference disagrees with what the operand signs force
         sat_po = !s1_a[UB] &&  s1_b[UB] &&  s1_diff[UB];
         sat_no =  s1_a[UB] && !s1_b[UB] && !s1_diff[UB];
         if (sat_po) begin
            sat_result = P_MAX;
         end else if (sat_no) begin
            sat_result = N_MAX;
         end
      end else begin
         sat_no = (s1_a < s1_b);
         if (sat_no && (UNSIG_CLAMP != 0)) begin
            sat_result = ZERO;
         end
      end
   end

   // stage 2: output register, frozen while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid   <= 1'b0;
         out_result <= ZERO;
         out_po     <= 1'b0;
         out_no     <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_result <= sat_result;
            out_po     <= sat_po;
            out_no     <= sat_no;
         end
      end
   end

`ifdef NO_OVERFLOW_SUB_STICKY_EN
   logic out_fire;
   assign out_fire = s2_valid && out_ready;

   // sticky flags: set by a completed output carrying the flag, set beats clear
   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_po <= 1'b0;
         sticky_no <= 1'b0;
      end else begin
         if (out_fire && out_po) begin
            sticky_po <= 1'b1;
         end else if (sticky_clr) begin
            sticky_po <= 1'b0;
         end
         if (out_fire && out_no) begin
            sticky_no <= 1'b1;
         end else if (sticky_clr) begin
            sticky_no <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_no_overflow_sub_pipe.sv
// tb/tb_no_overflow_sub_pipe.sv - randomized scoreboard bench for no_overflow_sub_pipe
module tb_no_overflow_sub_pipe;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_a = 8'h00;
   logic [7:0] in_b = 8'h00;
   logic       in_signed = 1'b0;
   logic       out_ready = 1'b0;

   logic       in_ready, out_valid, out_po, out_no;
   logic [7:0] out_result;
   logic       in_ready0, out_valid0, out_po0, out_no0;
   logic [7:0] out_result0;
`ifdef NO_OVERFLOW_SUB_STICKY_EN
   logic       sticky_clr = 1'b0;
   logic       sticky_po, sticky_no, sticky_po0, sticky_no0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // clamping instance
   no_overflow_sub_pipe #(.WIDTH(8), .UNSIG_CLAMP(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_po(out_po), .out_no(out_no)
`ifdef NO_OVERFLOW_SUB_STICKY_EN
      , .sticky_clr(sticky_clr), .sticky_po(sticky_po), .sticky_no(sticky_no)
`endif
   );

   // wrapping instance, same stimulus
   no_overflow_sub_pipe #(.WIDTH(8), .UNSIG_CLAMP(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .out_valid(out_valid0), .out_ready(out_ready), .out_result(out_result0),
      .out_po(out_po0), .out_no(out_no0)
`ifdef NO_OVERFLOW_SUB_STICKY_EN
      , .sticky_clr(sticky_clr), .sticky_po(sticky_po0), .sticky_no(sticky_no0)
`endif
   );

   typedef struct {
      logic [7:0] r;
      logic [7:0] r0;
      logic       po;
      logic       no;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // reference: exact integer difference, then clamp to the 8-bit range
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
      exp_t e;
      int   d;
      e.po = 1'b0;
      e.no = 1'b0;
      if (s) begin
         d = int'($signed(a)) - int'($signed(b));
         if (d > 127) begin
            e.r = 8'h7F; e.po = 1'b1;
         end else if (d < -128) begin
            e.r = 8'h80; e.no = 1'b1;
         end else begin
            e.r = d[7:0];
         end
         e.r0 = e.r;
      end else begin
         d = int'(a) - int'(b);
         e.r0 = d[7:0];
         if (d < 0) begin
            e.no = 1'b1; e.r = 8'h00;
         end else begin
            e.r = d[7:0];
         end
      end
      return e;
   endfunction

   // scoreboard update on every clock edge
   always @(posedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
      end else begin
         if (out_valid && out_ready && q.size() > 0) e = q.pop_front();
         if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_signed));
      end
   end

   // output compare, away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", in_ready, (q.size() < 2 || out_ready) ? 1 : 0);
         chk("in_ready_inst0", in_ready0, in_ready);
         chk("out_valid_inst0", out_valid0, out_valid);
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               chk("result", out_result, q[0].r);
               chk("po", out_po, q[0].po);
               chk("no", out_no, q[0].no);
               chk("result_wrap", out_result0, q[0].r0);
               chk("po_wrap", out_po0, q[0].po);
               chk("no_wrap", out_no0, q[0].no);
            end
         end
      end
   end

   function automatic logic [7:0] rnd8();
      case ($urandom_range(0, 6))
         0: return 8'h00;
         1: return 8'hFF;
         2: return 8'h80;
         3: return 8'h7F;
         4: return 8'h01;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
      logic acc;
      int   n;
      acc = 1'b0;
      n = 0;
      in_valid = 1'b1; in_a = a; in_b = b; in_signed = s;
      while (!acc && n < 50) begin
         #1;
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while ((q.size() != 0 || out_valid) && n < 50) begin
         step();
         n++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   logic [7:0] d_a  [9] = '{8'h7F, 8'h80, 8'h10, 8'h05, 8'hFF, 8'h00, 8'h00, 8'h5A, 8'h5A};
   logic [7:0] d_b  [9] = '{8'hFF, 8'h01, 8'h20, 8'h09, 8'h01, 8'hFF, 8'h80, 8'h5A, 8'h5A};
   logic       d_s  [9] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
   logic [7:0] d_r  [9] = '{8'h7F, 8'h80, 8'hF0, 8'h00, 8'hFE, 8'h00, 8'h7F, 8'h00, 8'h00};
   logic [7:0] d_r0 [9] = '{8'h7F, 8'h80, 8'hF0, 8'hFC, 8'hFE, 8'h01, 8'h7F, 8'h00, 8'h00};
   logic       d_po [9] = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
   logic       d_no [9] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};

   initial begin
      exp_t e;
      int   n, t_acc, t_out, t_last, nout, nacc;
      logic acc, have;
      logic [7:0] held;

      // model pinned to hand-computed values
      e = model(8'h7F, 8'hFF, 1'b1);
      chk("model_po", {e.r, 7'd0, e.po, 7'd0, e.no}, {8'h7F, 7'd0, 1'b1, 7'd0, 1'b0});
      e = model(8'h05, 8'h09, 1'b0);
      chk("model_uns", {e.r, e.r0, 7'd0, e.no}, {8'h00, 8'hFC, 7'd0, 1'b1});
      e = model(8'h80, 8'h01, 1'b1);
      chk("model_no", {e.r, 7'd0, e.no}, {8'h80, 7'd0, 1'b1});

      // reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_result", out_result, 0);
      chk("rst_flags", {out_po, out_no}, 0);
`ifdef NO_OVERFLOW_SUB_STICKY_EN
      chk("rst_sticky", {sticky_po, sticky_no}, 0);
`endif

      // directed vectors with literal expectations
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         send(d_a[i], d_b[i], d_s[i]);
         n = 0;
         while (!out_valid && n < 10) begin
            step();
            n++;
         end
         chk("dir_valid", out_valid, 1);
         chk("dir_result", out_result, d_r[i]);
         chk("dir_result_wrap", out_result0, d_r0[i]);
         chk("dir_flags", {out_po, out_no}, {d_po[i], d_no[i]});
         step();
`ifdef NO_OVERFLOW_SUB_STICKY_EN
         if (i == 0) chk("sticky_po_set", sticky_po, 1);
`endif
      end
`ifdef NO_OVERFLOW_SUB_STICKY_EN
      chk("sticky_persist", {sticky_po, sticky_no}, 2'b11);
      sticky_clr = 1'b1;
      step();
      sticky_clr = 1'b0;
      chk("sticky_cleared", {sticky_po, sticky_no}, 2'b00);
`endif

      // streaming: 10 back-to-back with out_ready held high
      t_acc = -1; t_out = -1; t_last = -1; nout = 0;
      for (int t = 0; t < 14; t++) begin
         in_valid = (t < 10);
         in_a = rnd8(); in_b = rnd8(); in_signed = 1'($urandom);
         #1;
         if (in_valid) chk("stream_in_ready", in_ready, 1);
         if (in_valid && in_ready && t_acc < 0) t_acc = t;
         if (out_valid) begin
            nout++;
            t_last = t;
            if (t_out < 0) t_out = t;
         end
         step();
      end
      in_valid = 1'b0;
      chk("stream_latency", t_out - t_acc, 2);
      chk("stream_count", nout, 10);
      chk("stream_contig", t_last - t_out, 9);

      // backpressure: consumer stalled for 5 cycles
      out_ready = 1'b0;
      nacc = 0; have = 1'b0; held = 8'h00;
      in_valid = 1'b1; in_a = rnd8(); in_b = rnd8(); in_signed = 1'($urandom);
      for (int t = 0; t < 5; t++) begin
         #1;
         acc = in_ready;
         if (acc) nacc++;
         if (out_valid) begin
            if (!have) begin
               held = out_result; have = 1'b1;
            end else begin
               chk("stall_hold", out_result, held);
            end
         end
         step();
         if (acc) begin
            in_a = rnd8(); in_b = rnd8(); in_signed = 1'($urandom);
         end
      end
      in_valid = 1'b0;
      chk("stall_accepts", nacc, 2);
      chk("stall_valid", out_valid, 1);
      drain();

      // randomized traffic
      for (int t = 0; t < 600; t++) begin
         if (!in_valid) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = rnd8(); in_b = rnd8(); in_signed = 1'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         acc = in_valid && in_ready;
         step();
         if (acc) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      drain();

      // reset with both stages full
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 8'h7F; in_b = 8'hFF; in_signed = 1'b1;
      step();
      in_a = 8'h00; in_b = 8'h80;
      step();
      in_valid = 1'b0;
      chk("full_before_rst", {out_valid, in_ready}, 2'b10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_mid_valid", out_valid, 0);
      chk("rst_mid_ready", in_ready, 1);
`ifdef NO_OVERFLOW_SUB_STICKY_EN
      chk("rst_mid_sticky", {sticky_po, sticky_no}, 0);
`endif
      out_ready = 1'b1;
      repeat (4) step();
      chk("rst_no_output", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
